ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameters SHALL be: WORD_W, default 8, data width; OP_W, default 3, opcode width; ADDR_W = WORD_W-OP_W, default 5, RAM address width.
REQ-002 Ports, in this order:
- clock  in  1  sole clock; all state changes on rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  WORD_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  WORD_W  read data, valid while cpu_ack=1.
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_ack, ldr_rdata: loader port, same directions, widths and meanings as the CPU port.
- RAM_NCE  out  1  RAM chip enable, active-low.
- RAM_NOE  out  1  RAM output enable, active-low.
- RAM_NWE  out  1  RAM write enable, active-low.
- ram_addr  out  ADDR_W  RAM address.
- ram_dout  out  WORD_W  data driven onto the tristate sysbus.
- ram_dout_en  out  1  sysbus drive enable.
- ram_din  in  WORD_W  sysbus read value.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-003 FSM SHALL have states IDLE, SETUP, ACCESS, DONE; no other reachable states.
REQ-004 IDLE: if any req is high, SHALL grant one requester, latch its we/addr/wdata into internal registers, and go to SETUP; otherwise stay in IDLE.
REQ-005 Arbitration SHALL be round-robin: a single requester is granted directly; if both request, grant the one not granted last; last_grant updates on each grant.
REQ-006 SETUP: RAM_NCE=0; ram_addr = latched address; if write, ram_dout_en=1; next state ACCESS.
REQ-007 ACCESS: RAM_NCE=0; read -> RAM_NOE=0; write -> RAM_NWE=0 and ram_dout_en=1; next state DONE.
REQ-008 Read: ram_din SHALL be captured on the clock edge leaving ACCESS.
REQ-009 DONE: RAM_NCE, RAM_NOE and RAM_NWE SHALL be 1; for writes, ram_dout_en stays 1 (hold time).
REQ-010 DONE: the granted port's ack SHALL be 1 for exactly one cycle, with rdata = captured data (reads); next state IDLE.
REQ-011 Latency: req sampled in IDLE at edge N gives ack high in the cycle after edge N+2; one transaction is 4 cycles including the IDLE turnaround.
REQ-012 RAM_NOE and RAM_NWE SHALL never be low in the same cycle; neither SHALL be low unless RAM_NCE=0.
REQ-013 ram_dout_en SHALL be 0 for every read transaction and in IDLE.
REQ-014 The ungranted port's ack SHALL be 0; its rdata SHALL hold its last value.
REQ-015 Deasserting req, or changing addr/we/wdata, after grant SHALL NOT alter the transaction; it completes and acks.
REQ-016 A requester holding req high through ack SHALL be treated as a new request at the next IDLE, subject to round-robin.
REQ-017 All outputs SHALL be registered or decoded only from state and latched registers, with no combinational path from req inputs.

Reset
REQ-018 n_reset=0 SHALL immediately force:
- state = IDLE
- RAM_NCE = RAM_NOE = RAM_NWE = 1
- ram_dout_en = 0, busy = 0
- both acks = 0
- ram_addr, ram_dout, cpu_rdata, ldr_rdata = 0
- last_grant = LDR, so the CPU wins the first tie.
REQ-019 Reset asserted mid-transaction SHALL abort it with no ack; after release, arbitration restarts from IDLE.

Structure
REQ-020 A shared package SHALL hold the state enum (IDLE, SETUP, ACCESS, DONE), the requester enum (CPU, LDR), and the default WORD_W/OP_W constants.
REQ-021 Round-robin selection SHALL be a sub-module rr_pick (inputs: two reqs and last_grant; output: grant); the FSM and datapath stay in ram_arbiter.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- CPU read, addr 5'h0A, ram_din=8'h3C: NCE low for 2 cycles, NOE low in ACCESS only, cpu_ack pulse with cpu_rdata=8'h3C, ram_dout_en=0 throughout.
- Loader write, addr 5'h1F, data 8'hA5: ram_dout=8'hA5 with en=1 for SETUP/ACCESS/DONE, NWE low in ACCESS only, ldr_ack one pulse, cpu_ack stays 0.
- Both req held high from reset for 4 transactions: grants CPU, LDR, CPU, LDR; acks every 4 cycles.
- CPU drops req and changes addr 5'h03->5'h07 one cycle after grant: RAM sees 5'h03, cpu_ack still pulses.
- n_reset pulsed low during ACCESS of a write: NWE/NCE high and en=0 within the same cycle, no ack, next request served normally.
- Throughout all scenarios, an assertion checks NOE and NWE are never both low.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared types and default widths for the RAM arbiter
package ram_arbiter_pkg;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_OP_W   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        CPU = 1'b0,
        LDR = 1'b1
    } requester_t;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// rtl/ram_arbiter_rr_pick.sv - two-way round-robin selection between CPU and loader
module rr_pick
    import ram_arbiter_pkg::*;
(
    input  logic       cpu_req,
    input  logic       ldr_req,
    input  requester_t last_grant,
    output requester_t grant
);

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant = CPU;
        if (cpu_req && ldr_req) begin
            grant = (last_grant == CPU) ? LDR : CPU;
        end else if (ldr_req) begin
            grant = LDR;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one async SRAM between CPU and loader with a 4-cycle access FSM
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int OP_W   = DEF_OP_W,
    parameter int ADDR_W = WORD_W - OP_W
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [WORD_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [WORD_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [WORD_W-1:0] ldr_rdata,
    output logic              RAM_NCE,
    output logic              RAM_NOE,
    output logic              RAM_NWE,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_dout,
    output logic              ram_dout_en,
    input  logic [WORD_W-1:0] ram_din,
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    requester_t        grant;
    requester_t        last_grant;
    requester_t        pick;
    logic              any_req;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [WORD_W-1:0] lat_wdata;

    assign any_req = cpu_req | ldr_req;

    rr_pick u_rr_pick (
        .cpu_req    (cpu_req),
        .ldr_req    (ldr_req),
        .last_grant (last_grant),
        .grant      (pick)
    );

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus strobe decode; strobes depend only on state and latched
    // registers so nothing on the RAM side follows the request inputs.
    always_comb begin
        state_nxt   = state;
        RAM_NCE     = 1'b1;
        RAM_NOE     = 1'b1;
        RAM_NWE     = 1'b1;
        ram_dout_en = 1'b0;
        cpu_ack     = 1'b0;
        ldr_ack     = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_req) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                RAM_NCE     = 1'b0;
                ram_dout_en = lat_we;
                state_nxt   = ACCESS;
            end
            ACCESS: begin
                RAM_NCE     = 1'b0;
                RAM_NOE     = lat_we;
                RAM_NWE     = ~lat_we;
                ram_dout_en = lat_we;
                state_nxt   = DONE;
            end
            DONE: begin
                ram_dout_en = lat_we;
                cpu_ack     = (grant == CPU);
                ldr_ack     = (grant == LDR);
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            grant      <= CPU;
            last_grant <= LDR;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cpu_rdata  <= '0;
            ldr_rdata  <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                grant      <= pick;
                last_grant <= pick;
                lat_we     <= (pick == CPU) ? cpu_we    : ldr_we;
                lat_addr   <= (pick == CPU) ? cpu_addr  : ldr_addr;
                lat_wdata  <= (pick == CPU) ? cpu_wdata : ldr_wdata;
            end
            // Read data is sampled as OE is released, at the end of ACCESS.
            if (state == ACCESS && !lat_we) begin
                if (grant == CPU) begin
                    cpu_rdata <= ram_din;
                end else begin
                    ldr_rdata <= ram_din;
                end
            end
        end
    end

    assign ram_addr = lat_addr;
    assign ram_dout = lat_wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter with directed scenarios
module tb_ram_arbiter;

    logic       clock = 1'b0;
    logic       n_reset = 1'b0;
    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [4:0] cpu_addr = '0;
    logic [7:0] cpu_wdata = '0;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;
    logic       ldr_req = 1'b0, ldr_we = 1'b0;
    logic [4:0] ldr_addr = '0;
    logic [7:0] ldr_wdata = '0;
    logic       ldr_ack;
    logic [7:0] ldr_rdata;
    logic       RAM_NCE, RAM_NOE, RAM_NWE;
    logic [4:0] ram_addr;
    logic [7:0] ram_dout;
    logic       ram_dout_en;
    logic [7:0] ram_din = '0;
    logic       busy;

    typedef struct {
        logic       port;
        logic       we;
        logic [4:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic       seen_valid = 1'b0;
    logic       seen_we = 1'b0;
    logic [4:0] seen_addr = '0;
    logic [7:0] seen_data = '0;

    ram_arbiter dut (
        .clock       (clock),
        .n_reset     (n_reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .ldr_req     (ldr_req),
        .ldr_we      (ldr_we),
        .ldr_addr    (ldr_addr),
        .ldr_wdata   (ldr_wdata),
        .ldr_ack     (ldr_ack),
        .ldr_rdata   (ldr_rdata),
        .RAM_NCE     (RAM_NCE),
        .RAM_NOE     (RAM_NOE),
        .RAM_NWE     (RAM_NWE),
        .ram_addr    (ram_addr),
        .ram_dout    (ram_dout),
        .ram_dout_en (ram_dout_en),
        .ram_din     (ram_din),
        .busy        (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(logic port, logic we, logic [4:0] addr, logic [7:0] data);
        exp_t e;
        e.port = port;
        e.we   = we;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

    // Monitor: records the RAM strobe phase, then scores each ack against the queue.
    always @(negedge clock) begin
        checks++;
        assert (!(!RAM_NOE && !RAM_NWE) && ((RAM_NOE && RAM_NWE) || !RAM_NCE)) else begin
            failures++;
            $display("FAIL strobe_rule noe=%0b nwe=%0b nce=%0b", RAM_NOE, RAM_NWE, RAM_NCE);
        end
        if (!n_reset) begin
            seen_valid = 1'b0;
        end else begin
            if (!RAM_NOE || !RAM_NWE) begin
                seen_valid = 1'b1;
                seen_we    = !RAM_NWE;
                seen_addr  = ram_addr;
                seen_data  = ram_dout;
            end
            if (cpu_ack || ldr_ack) begin
                check("ack_exclusive", {31'b0, cpu_ack & ldr_ack}, 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_ack", {30'b0, cpu_ack, ldr_ack}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_port", {31'b0, ldr_ack}, {31'b0, e.port});
                    check("sb_strobe_seen", {31'b0, seen_valid}, 32'd1);
                    check("sb_we", {31'b0, seen_we}, {31'b0, e.we});
                    check("sb_addr", {27'b0, seen_addr}, {27'b0, e.addr});
                    if (e.we)
                        check("sb_wdata", {24'b0, seen_data}, {24'b0, e.data});
                    else
                        check("sb_rdata", {24'b0, (cpu_ack ? cpu_rdata : ldr_rdata)}, {24'b0, e.data});
                end
                seen_valid = 1'b0;
            end
        end
    end

    // bits per cycle: {NCE, NOE, NWE, dout_en, cpu_ack, ldr_ack}
    task automatic trace(string name, logic [23:0] exp);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check($sformatf("%s_c%0d", name, i),
                  {26'b0, RAM_NCE, RAM_NOE, RAM_NWE, ram_dout_en, cpu_ack, ldr_ack},
                  {26'b0, exp[23-6*i -: 6]});
        end
    endtask

    task automatic wait_ack(string name, int budget, output int at);
        int  n;
        logic found;
        n = 0;
        found = 1'b0;
        while (n < budget && !found) begin
            @(negedge clock);
            if (cpu_ack || ldr_ack) found = 1'b1;
            n++;
        end
        check({name, "_ack_seen"}, {31'b0, found}, 32'd1);
        at = cyc;
    endtask

    initial begin
        int t_prev, t_now;

        // Reset state
        @(negedge clock);
        check("rst_ctrl", {25'b0, RAM_NCE, RAM_NOE, RAM_NWE, ram_dout_en, busy, cpu_ack, ldr_ack}, 32'b1110000);
        check("rst_addr_dout", {19'b0, ram_addr, ram_dout}, 32'd0);
        check("rst_rdata", {16'b0, cpu_rdata, ldr_rdata}, 32'd0);
        #1 n_reset = 1'b1;
        repeat (2) @(negedge clock);

        // CPU read 0x0A -> 0x3C
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h0A; ram_din = 8'h3C;
        sb.push_back(mk(1'b0, 1'b0, 5'h0A, 8'h3C));
        @(posedge clock); #1;
        cpu_req = 1'b0;
        trace("cpu_read", {6'b011000, 6'b001000, 6'b111010, 6'b111000});

        // Loader write 0x1F <- 0xA5
        @(posedge clock); #1;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 5'h1F; ldr_wdata = 8'hA5; ram_din = 8'h00;
        sb.push_back(mk(1'b1, 1'b1, 5'h1F, 8'hA5));
        @(posedge clock); #1;
        ldr_req = 1'b0;
        trace("ldr_write", {6'b011100, 6'b010100, 6'b111101, 6'b111000});
        check("cpu_rdata_hold", {24'b0, cpu_rdata}, 32'h3C);

        // Both requesting from reset: CPU, LDR, CPU, LDR, one ack every 4 cycles
        @(posedge clock); #1;
        n_reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h04;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 5'h11; ldr_wdata = 8'h77;
        ram_din = 8'hC3;
        for (int k = 0; k < 2; k++) begin
            sb.push_back(mk(1'b0, 1'b0, 5'h04, 8'hC3));
            sb.push_back(mk(1'b1, 1'b1, 5'h11, 8'h77));
        end
        @(negedge clock);
        n_reset = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ack($sformatf("rr%0d", k), 8, t_now);
            if (k > 0) check($sformatf("rr%0d_period", k), t_now - t_prev, 32'd4);
            t_prev = t_now;
        end
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        repeat (3) @(negedge clock);
        check("rr_idle_busy", {31'b0, busy}, 32'd0);
        check("ldr_rdata_hold", {24'b0, ldr_rdata}, 32'h00);

        // CPU drops req and moves addr after grant
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h03; ram_din = 8'h5E;
        sb.push_back(mk(1'b0, 1'b0, 5'h03, 8'h5E));
        @(posedge clock); #1;
        cpu_req = 1'b0; cpu_addr = 5'h07;
        wait_ack("drop", 6, t_now);
        repeat (2) @(negedge clock);

        // Reset during ACCESS of a loader write aborts without an ack
        @(posedge clock); #1;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 5'h0C; ldr_wdata = 8'h99;
        @(posedge clock); #1;
        ldr_req = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("abort_in_access", {30'b0, RAM_NWE, ram_dout_en}, 32'b01);
        #1 n_reset = 1'b0;
        #1;
        check("abort_ctrl", {25'b0, RAM_NCE, RAM_NOE, RAM_NWE, ram_dout_en, busy, cpu_ack, ldr_ack}, 32'b1110000);
        @(posedge clock); #1;
        n_reset = 1'b1;
        repeat (4) @(negedge clock);

        // Normal service after the abort
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h02; cpu_wdata = 8'h3B;
        sb.push_back(mk(1'b0, 1'b1, 5'h02, 8'h3B));
        @(posedge clock); #1;
        cpu_req = 1'b0;
        wait_ack("post_abort", 6, t_now);
        repeat (3) @(negedge clock);

        check("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
